// File: rtl/rr_arbiter_timeout_if.sv
// Request/grant bundle for the round-robin arbiter.
// The requester side uses the master view and the arbiter uses the slave view.
interface rr_arbiter_timeout_if #(
  parameter int N = 4
);
  localparam int IW = $clog2(N);

  logic [N-1:0]  r;        // request vector
  logic [N-1:0]  g;        // one-hot grant vector
  logic          gvalid;   // any grant active
  logic [IW-1:0] gid;      // index of the granted requester, 0 when idle
  logic          timeout;  // pulse: grant forcibly revoked

  modport master (output r, input g, gvalid, gid, timeout);
  modport slave  (input r, output g, gvalid, gid, timeout);
endinterface

// File: rtl/rr_arbiter_timeout.sv
// Registered round-robin arbiter with a bounded hold time.
// A grant lasts while its owner keeps requesting, up to MAXHOLD cycles.
// Every grant is followed by a one-cycle gap. An owner cut off by the hold
// limit is masked until it drops its request for at least one cycle.
module rr_arbiter_timeout #(
  parameter int N       = 4,
  parameter int MAXHOLD = 16
) (
  input  logic                 Clock,
  input  logic                 Reset,
  rr_arbiter_timeout_if.slave  bus
);
  localparam int IW = $clog2(N);
  localparam int CW = $clog2(MAXHOLD);
  localparam logic [N-1:0] ONE = N'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t        state;
  logic [N-1:0]  g_q;
  logic          gvalid_q;
  logic [IW-1:0] gid_q;
  logic          timeout_q;
  logic [IW-1:0] last;     // most recent owner; the search starts after it
  logic [CW-1:0] hold;     // cycles the current owner has held, minus one
  logic [N-1:0]  mask;     // requesters locked out after a forced release

  logic [N-1:0]  eligible;
  logic          win_found;
  logic [IW-1:0] win;
  logic [IW-1:0] idx;

  // Pick the first eligible requester, searching upward from last+1 with wrap.
  always_comb begin
    // NOTE: every variable written here gets a default first so no latch is inferred.
    eligible  = bus.r & ~mask;
    win_found = 1'b0;
    win       = '0;
    idx       = '0;
    for (int off = 1; off <= N; off++) begin
      idx = IW'((int'(last) + off) % N);
      if (!win_found && eligible[idx]) begin
        win_found = 1'b1;
        win       = idx;
      end
    end
  end

  // Arbitration state machine with registered grant outputs.
  always_ff @(posedge Clock) begin
    // NOTE: reset is synchronous, so it is sampled on the clock edge like any input.
    if (Reset) begin
      state     <= IDLE;
      g_q       <= '0;
      gvalid_q  <= 1'b0;
      gid_q     <= '0;
      timeout_q <= 1'b0;
      last      <= IW'(N - 1);
      hold      <= '0;
      mask      <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout; later assignments to a mask bit override the default.
      timeout_q <= 1'b0;
      mask      <= mask & bus.r;
      unique case (state)
        IDLE, GAP: begin
          if (win_found) begin
            state    <= GRANT;
            g_q      <= ONE << win;
            gvalid_q <= 1'b1;
            gid_q    <= win;
            last     <= win;
            hold     <= '0;
          end else begin
            state <= IDLE;
          end
        end
        GRANT: begin
          if (!bus.r[gid_q]) begin
            state    <= GAP;
            g_q      <= '0;
            gvalid_q <= 1'b0;
            gid_q    <= '0;
          end else if (hold == CW'(MAXHOLD - 1)) begin
            state       <= GAP;
            g_q         <= '0;
            gvalid_q    <= 1'b0;
            gid_q       <= '0;
            timeout_q   <= 1'b1;
            mask[gid_q] <= 1'b1;
          end else begin
            hold <= hold + 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          g_q      <= '0;
          gvalid_q <= 1'b0;
          gid_q    <= '0;
        end
      endcase
    end
  end

  assign bus.g       = g_q;
  assign bus.gvalid  = gvalid_q;
  assign bus.gid     = gid_q;
  assign bus.timeout = timeout_q;
endmodule
